tts_monitor: RTL and testbench
==============================

Name: tts_monitor

Overview:
- Receive-side counterpart of the Rider TTS reporter: samples a 4-bit TTS state arriving from another clock domain or link, synchronizes and debounces it, then decodes it into one-hot status flags.
- Keeps saturating statistics (state-entry counts, non-ready cycle count, sticky error) for slow-control readout.
- Sits in the DAQ/test-stand logic that consumes a Rider's TTS output, or in a loopback path for self-test.

Parameters:
STABLE_CYCLES, 4, consecutive post-sync cycles a new code must hold before acceptance; legal range 1..255
CNT_WIDTH, 16, width of every statistics counter

Ports:
clk  input  1  user interface clock
reset  input  1  asynchronous, active-high reset
tts_in  input  4  raw TTS code, asynchronous to clk
clear_counters  input  1  single-cycle synchronous pulse; clears statistics and sticky flag
tts_code  output  4  accepted (debounced) TTS code
state_ready  output  1  accepted code == 1000
state_warning  output  1  accepted code == 0001 (overflow warning)
state_sync_lost  output  1  accepted code == 0010
state_error  output  1  accepted code == 1100
state_disconnected  output  1  accepted code == 0000 or 1111
state_invalid  output  1  accepted code is any other value
change_strobe  output  1  one-cycle pulse when tts_code changes
error_sticky  output  1  set on entry to error or invalid; held until clear_counters
error_count  output  CNT_WIDTH  entries into error state
sync_lost_count  output  CNT_WIDTH  entries into sync-lost state
warning_count  output  CNT_WIDTH  entries into overflow-warning state
busy_cycles  output  CNT_WIDTH  cycles the accepted code was not ready

Behaviour:
- Reset is asynchronous and active-high.
- Reset values:
  - tts_code = 0000; state_disconnected = 1; all other state_* = 0.
  - sync1, sync2, cand = 0000; stability cnt = 0.
  - change_strobe = 0; error_sticky = 0; all counters = 0.
- Synchronizer: two flops, sync1 <= tts_in, then sync2 <= sync1.
- Debounce, evaluated every edge:
  - cand <= sync2.
  - If sync2 != cand: cnt <= 0.
  - Else if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Acceptance condition: sync2 == cand, cnt == STABLE_CYCLES-1, and cand != tts_code. When it holds, tts_code <= cand and change_strobe <= 1 for one cycle.
- Latency: a clean step first captured into sync1 at edge k appears on tts_code after edge k+2+STABLE_CYCLES (edge k+6 at the default).
- Glitch rejection: a pulse lasting fewer than STABLE_CYCLES+1 sync2 cycles never reaches tts_code. Re-settling to the current tts_code value produces no strobe.
- Decode is combinational from the tts_code register. Exactly one state_* flag is high at all times.
- Counters:
  - error_count, sync_lost_count and warning_count increment on the cycle change_strobe is asserted with the matching new code.
  - busy_cycles increments every cycle tts_code != 1000.
  - All counters saturate at all-ones; no wrap-around.
- error_sticky is set when change_strobe fires with a new code of error or invalid.
- clear_counters:
  - Zeros all counters and error_sticky on the next edge.
  - If it coincides with a counting event, clear wins and the counter reads 0.
  - If it coincides with a sticky-set event, set wins and error_sticky reads 1.
  - Does not affect tts_code, the synchronizer or the debounce logic.
- Reset mid-operation: every register returns to its reset value immediately. A pending debounce is discarded, and tts_code shows disconnected until a new code is accepted.

Optional Feature:
- Macro TTS_HISTORY_EN.
- When defined:
  - Adds output port tts_history [15:0] holding the last four accepted codes, newest in [3:0].
  - On each change_strobe the register shifts left by 4 and the new code enters [3:0].
  - Reset value and clear_counters value are 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Hold tts_in=1000 after reset, STABLE_CYCLES=4 -> change_strobe exactly 6 edges after the first sample; tts_code=1000; state_ready=1; busy_cycles stops incrementing.
- From ready, drive a 1100 pulse 3 cycles wide, then 1000 -> no change_strobe; error_count=0; error_sticky=0.
- Ready -> 1100 held 20 cycles -> ready -> error_count=1; error_sticky=1; busy_cycles ~= 20; state_error high for exactly 20 accepted cycles.
- Drive code 0101 -> state_invalid=1; error_sticky=1; no counter except busy_cycles increments.
- CNT_WIDTH=4, toggle ready/0010 twenty times -> sync_lost_count saturates at 15 and holds; clear_counters pulse -> 0; clear_counters coincident with an error entry -> error_count=0 and error_sticky=1.
- Assert reset mid-debounce of 0001 -> tts_code=0000 and state_disconnected=1 immediately; with TTS_HISTORY_EN, sequence 1000, 0010, 1000, 1100 gives tts_history=16'h82_8C.

Source files
------------

// File: rtl/tts_monitor_if.sv
// Status/statistics bundle between a TTS monitor and its consumer.
// The optional tts_history port exists only when TTS_HISTORY_EN is defined.
interface tts_monitor_if #(
    parameter int CNT_WIDTH = 16
);
    logic [3:0]           tts_in;
    logic                 clear_counters;
    logic [3:0]           tts_code;
    logic                 state_ready;
    logic                 state_warning;
    logic                 state_sync_lost;
    logic                 state_error;
    logic                 state_disconnected;
    logic                 state_invalid;
    logic                 change_strobe;
    logic                 error_sticky;
    logic [CNT_WIDTH-1:0] error_count;
    logic [CNT_WIDTH-1:0] sync_lost_count;
    logic [CNT_WIDTH-1:0] warning_count;
    logic [CNT_WIDTH-1:0] busy_cycles;
`ifdef TTS_HISTORY_EN
    logic [15:0]          tts_history;
`endif

    modport master (
`ifdef TTS_HISTORY_EN
        input  tts_history,
`endif
        output tts_in, clear_counters,
        input  tts_code, state_ready, state_warning, state_sync_lost, state_error,
        input  state_disconnected, state_invalid, change_strobe, error_sticky,
        input  error_count, sync_lost_count, warning_count, busy_cycles
    );

    modport slave (
`ifdef TTS_HISTORY_EN
        output tts_history,
`endif
        input  tts_in, clear_counters,
        output tts_code, state_ready, state_warning, state_sync_lost, state_error,
        output state_disconnected, state_invalid, change_strobe, error_sticky,
        output error_count, sync_lost_count, warning_count, busy_cycles
    );
endinterface

// File: rtl/tts_monitor.sv
// Receive-side TTS monitor: 2-flop sync, debounce, one-hot decode, saturating stats.
// Define TTS_HISTORY_EN to add the 4-deep accepted-code history register.
module tts_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic           clk,
    input  logic           reset,
    tts_monitor_if.slave   bus
);
    localparam logic [7:0]           LAST    = 8'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [3:0] C_READY = 4'b1000;
    localparam logic [3:0] C_WARN  = 4'b0001;
    localparam logic [3:0] C_SLOST = 4'b0010;
    localparam logic [3:0] C_ERROR = 4'b1100;

    logic [3:0]           sync1, sync2, cand, code_q;
    logic [7:0]           cnt;
    logic                 accept, strobe_q, sticky_q, new_bad;
    logic [CNT_WIDTH-1:0] err_q, slost_q, warn_q, busy_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Anything not a named healthy/disconnected code counts as error-class.
    assign new_bad = !(cand inside {C_READY, C_WARN, C_SLOST, 4'b0000, 4'b1111});
    assign accept  = (sync2 == cand) && (cnt == LAST) && (cand != code_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            cnt      <= '0;
            code_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            sync1    <= bus.tts_in;
            sync2    <= sync1;
            cand     <= sync2;
            if (sync2 != cand)
                cnt <= '0;
            else if (cnt < LAST)
                cnt <= cnt + 1'b1;
            strobe_q <= accept;
            if (accept)
                code_q <= cand;
        end
    end

    // Stats update on the acceptance edge, so they already reflect the entry
    // during the cycle change_strobe is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q    <= '0;
            slost_q  <= '0;
            warn_q   <= '0;
            busy_q   <= '0;
            sticky_q <= 1'b0;
        end else if (bus.clear_counters) begin
            err_q    <= '0;
            slost_q  <= '0;
            warn_q   <= '0;
            busy_q   <= '0;
            sticky_q <= accept && new_bad;
        end else begin
            if (accept && cand == C_ERROR) err_q   <= sat_inc(err_q);
            if (accept && cand == C_SLOST) slost_q <= sat_inc(slost_q);
            if (accept && cand == C_WARN)  warn_q  <= sat_inc(warn_q);
            if (code_q != C_READY)         busy_q  <= sat_inc(busy_q);
            if (accept && new_bad)         sticky_q <= 1'b1;
        end
    end

`ifdef TTS_HISTORY_EN
    logic [15:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hist_q <= '0;
        else if (bus.clear_counters)
            hist_q <= '0;
        else if (accept)
            hist_q <= {hist_q[11:0], cand};
    end

    assign bus.tts_history = hist_q;
`endif

    always_comb begin
        bus.state_ready        = 1'b0;
        bus.state_warning      = 1'b0;
        bus.state_sync_lost    = 1'b0;
        bus.state_error        = 1'b0;
        bus.state_disconnected = 1'b0;
        bus.state_invalid      = 1'b0;
        case (code_q)
            C_READY:         bus.state_ready        = 1'b1;
            C_WARN:          bus.state_warning      = 1'b1;
            C_SLOST:         bus.state_sync_lost    = 1'b1;
            C_ERROR:         bus.state_error        = 1'b1;
            4'b0000, 4'b1111: bus.state_disconnected = 1'b1;
            default:         bus.state_invalid      = 1'b1;
        endcase
    end

    assign bus.tts_code        = code_q;
    assign bus.change_strobe   = strobe_q;
    assign bus.error_sticky    = sticky_q;
    assign bus.error_count     = err_q;
    assign bus.sync_lost_count = slost_q;
    assign bus.warning_count   = warn_q;
    assign bus.busy_cycles     = busy_q;
endmodule

// File: tb/tb_tts_monitor.sv
// Directed bench for tts_monitor: vector table plus hand-written corner sequences.
// A second instance with CNT_WIDTH=4 shares the stimulus for saturation checks.
module tb_tts_monitor;
    logic clk;
    logic reset;

    tts_monitor_if #(.CNT_WIDTH(16)) bus0();
    tts_monitor_if #(.CNT_WIDTH(4))  bus1();

    tts_monitor #(.STABLE_CYCLES(4), .CNT_WIDTH(16)) u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    tts_monitor #(.STABLE_CYCLES(4), .CNT_WIDTH(4))  u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] F_RDY = 6'b100000;
    localparam logic [5:0] F_WRN = 6'b010000;
    localparam logic [5:0] F_SL  = 6'b001000;
    localparam logic [5:0] F_ERR = 6'b000100;
    localparam logic [5:0] F_DIS = 6'b000010;
    localparam logic [5:0] F_INV = 6'b000001;

    typedef struct {
        logic [3:0] code;
        int         hold;
        bit         clr;
        logic [3:0] exp_code;
        logic [5:0] exp_flags;
        int         exp_strobes;
        int         exp_err;
        int         exp_sync;
        int         exp_warn;
        bit         exp_sticky;
        int         exp_busy;
    } vec_t;

    vec_t vecs[17];
    int   tests = 0;
    int   fails = 0;
    int   strobes;
    int   first_strobe;

    function automatic logic [5:0] flags0();
        return {bus0.state_ready, bus0.state_warning, bus0.state_sync_lost,
                bus0.state_error, bus0.state_disconnected, bus0.state_invalid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] c);
        bus0.tts_in = c;
        bus1.tts_in = c;
    endtask

    task automatic set_clr(input logic b);
        bus0.clear_counters = b;
        bus1.clear_counters = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus0.change_strobe === 1'b1) strobes++;
    endtask

    task automatic hold(input logic [3:0] c, input int n);
        set_in(c);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        set_in(v.code);
        strobes = 0;
        for (int i = 0; i < v.hold; i++) begin
            set_clr(v.clr && i == 0);
            tick();
        end
        set_clr(1'b0);
        check($sformatf("v%0d code", idx),    32'(bus0.tts_code),        32'(v.exp_code));
        check($sformatf("v%0d flags", idx),   32'(flags0()),             32'(v.exp_flags));
        check($sformatf("v%0d strobes", idx), 32'(strobes),              32'(v.exp_strobes));
        check($sformatf("v%0d err", idx),     32'(bus0.error_count),     32'(v.exp_err));
        check($sformatf("v%0d sync", idx),    32'(bus0.sync_lost_count), 32'(v.exp_sync));
        check($sformatf("v%0d warn", idx),    32'(bus0.warning_count),   32'(v.exp_warn));
        check($sformatf("v%0d sticky", idx),  32'(bus0.error_sticky),    32'(v.exp_sticky));
        check($sformatf("v%0d busy", idx),    32'(bus0.busy_cycles),     32'(v.exp_busy));
    endtask

    initial begin
        //           code     hold clr exp_code flags  strb err sync warn stk busy
        vecs[0]  = '{4'b1100,  3, 0, 4'b1000, F_RDY, 0, 0, 0, 0, 0,  7};
        vecs[1]  = '{4'b1000, 10, 0, 4'b1000, F_RDY, 0, 0, 0, 0, 0,  7};
        vecs[2]  = '{4'b1100, 20, 0, 4'b1100, F_ERR, 1, 1, 0, 0, 1, 20};
        vecs[3]  = '{4'b1000, 10, 0, 4'b1000, F_RDY, 1, 1, 0, 0, 1, 27};
        vecs[4]  = '{4'b1000,  8, 1, 4'b1000, F_RDY, 0, 0, 0, 0, 0,  0};
        vecs[5]  = '{4'b0101, 10, 0, 4'b0101, F_INV, 1, 0, 0, 0, 1,  3};
        vecs[6]  = '{4'b0001, 10, 0, 4'b0001, F_WRN, 1, 0, 0, 1, 1, 13};
        vecs[7]  = '{4'b0010, 10, 0, 4'b0010, F_SL,  1, 0, 1, 1, 1, 23};
        vecs[8]  = '{4'b1111, 10, 0, 4'b1111, F_DIS, 1, 0, 1, 1, 1, 33};
        vecs[9]  = '{4'b0000, 10, 0, 4'b0000, F_DIS, 1, 0, 1, 1, 1, 43};
        vecs[10] = '{4'b0001,  2, 0, 4'b0000, F_DIS, 0, 0, 1, 1, 1, 45};
        vecs[11] = '{4'b0000, 10, 0, 4'b0000, F_DIS, 0, 0, 1, 1, 1, 55};
        vecs[12] = '{4'b1000, 10, 0, 4'b1000, F_RDY, 1, 0, 1, 1, 1, 62};
        vecs[13] = '{4'b0010,  4, 0, 4'b1000, F_RDY, 0, 0, 1, 1, 1, 62};
        vecs[14] = '{4'b1000, 10, 0, 4'b1000, F_RDY, 0, 0, 1, 1, 1, 62};
        vecs[15] = '{4'b0010,  5, 0, 4'b1000, F_RDY, 0, 0, 1, 1, 1, 62};
        vecs[16] = '{4'b1000, 12, 0, 4'b1000, F_RDY, 2, 0, 2, 1, 1, 67};

        reset = 1'b1;
        set_in(4'b0000);
        set_clr(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst code",   32'(bus0.tts_code),     32'h0);
        check("rst flags",  32'(flags0()),          32'(F_DIS));
        check("rst strobe", 32'(bus0.change_strobe), 32'h0);
        check("rst sticky", 32'(bus0.error_sticky), 32'h0);
        check("rst busy",   32'(bus0.busy_cycles),  32'h0);
        check("rst err",    32'(bus0.error_count),  32'h0);

        // First acceptance: strobe exactly six edges after the first sample.
        reset = 1'b0;
        set_in(4'b1000);
        strobes = 0;
        first_strobe = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus0.change_strobe === 1'b1 && first_strobe < 0) first_strobe = i;
        end
        check("lat edge",    32'(first_strobe),     32'd6);
        check("lat strobes", 32'(strobes),          32'd1);
        check("lat code",    32'(bus0.tts_code),    32'h8);
        check("lat flags",   32'(flags0()),         32'(F_RDY));
        check("lat busy",    32'(bus0.busy_cycles), 32'd7);
        hold(4'b1000, 5);
        check("lat busy hold", 32'(bus0.busy_cycles), 32'd7);

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Twenty ready/sync-lost round trips saturate the narrow instance.
        for (int i = 0; i < 20; i++) begin
            hold(4'b0010, 8);
            hold(4'b1000, 8);
        end
        check("sat sync16", 32'(bus0.sync_lost_count), 32'd22);
        check("sat sync4",  32'(bus1.sync_lost_count), 32'd15);
        check("sat busy4",  32'(bus1.busy_cycles),     32'd15);
        set_clr(1'b1);
        tick();
        set_clr(1'b0);
        check("clr sync4",  32'(bus1.sync_lost_count), 32'd0);
        check("clr busy4",  32'(bus1.busy_cycles),     32'd0);
        check("clr sync16", 32'(bus0.sync_lost_count), 32'd0);

        // Clear coincident with an error entry: count cleared, sticky set.
        set_in(4'b1100);
        strobes = 0;
        for (int i = 0; i < 6; i++) tick();
        set_clr(1'b1);
        tick();
        set_clr(1'b0);
        check("coin strobe", 32'(bus0.change_strobe), 32'h1);
        check("coin code",   32'(bus0.tts_code),      32'hc);
        check("coin err",    32'(bus0.error_count),   32'd0);
        check("coin sticky", 32'(bus0.error_sticky),  32'h1);
        check("coin err4",   32'(bus1.error_count),   32'd0);
        hold(4'b1100, 4);
        check("coin err hold", 32'(bus0.error_count), 32'd0);

        // Reset in the middle of a 0001 debounce.
        hold(4'b1000, 10);
        hold(4'b0001, 4);
        #2;
        reset = 1'b1;
        #1;
        check("amid code",   32'(bus0.tts_code),     32'h0);
        check("amid flags",  32'(flags0()),          32'(F_DIS));
        check("amid sticky", 32'(bus0.error_sticky), 32'h0);
        set_in(4'b0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        strobes = 0;
        hold(4'b0000, 10);
        check("post rst strobes", 32'(strobes),        32'd0);
        check("post rst code",    32'(bus0.tts_code),  32'h0);

`ifdef TTS_HISTORY_EN
        hold(4'b1000, 10);
        hold(4'b0010, 10);
        hold(4'b1000, 10);
        hold(4'b1100, 10);
        check("history", 32'(bus0.tts_history), 32'h828c);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
